// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB register-file completer.
package apb_slave_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int unsigned MAX_WAIT = 32'd15;
  localparam int unsigned CNT_W    = 32'd4;

  // Word index of a byte address: drop the byte-offset bits of one data word.
  function automatic logic [63:0] idx_of(input logic [63:0] addr, input int unsigned data_w);
    logic [63:0] idx;
    case (data_w)
      32'd8:   idx = addr;
      32'd16:  idx = addr >> 1;
      default: idx = addr >> 2;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Wait-state counter: cleared on load, counts up to WAIT_CYCLES and holds there.
module apb_wait_ctr
  import apb_slave_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 32'd0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done,
  output logic done_nxt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && (cnt_q < LAST)) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // done_nxt lets the owner register pready so it is high exactly when cnt==WAIT_CYCLES.
  assign done     = (cnt_q == LAST);
  assign done_nxt = (cnt_d == LAST);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer with a bank of NUM_REGS registers, programmable wait states and error response.
// Optional byte-lane write strobes are enabled by defining APB_SLAVE_PSTRB_EN.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int unsigned         ADDR_W      = 32'd32,
  parameter int unsigned         DATA_W      = 32'd32,
  parameter int unsigned         NUM_REGS    = 32'd16,
  parameter int unsigned         WAIT_CYCLES = 32'd0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [DATA_W-1:0]            pwdata,
`ifdef APB_SLAVE_PSTRB_EN
  input  logic [DATA_W/8-1:0]          pstrb,
`endif
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_d,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_wr
);

  localparam int unsigned LANES = DATA_W / 32'd8;
  localparam int unsigned IDX_W = (NUM_REGS > 32'd1) ? $clog2(NUM_REGS) : 32'd1;

  apb_state_e                 state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic                       write_q, write_d;
  logic [DATA_W-1:0]          wdata_q, wdata_d;
  logic [LANES-1:0]           strb_q, strb_d;
  logic [DATA_W-1:0]          prdata_q, prdata_d;
  logic                       pready_q, pready_d;
  logic                       pslverr_q, pslverr_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]        reg_wr_q, reg_wr_d;

  logic                       load_s, en_s, done_s, done_nxt_s;
  logic                       in_range_s, ro_s;
  logic [63:0]                idx_s;
  logic [IDX_W-1:0]           sel_s;
  logic [DATA_W-1:0]          rdata_s, merged_s;

  apb_wait_ctr #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_ctr (
    .clk      (pclk),
    .rst      (preset),
    .load     (load_s),
    .en       (en_s),
    .done     (done_s),
    .done_nxt (done_nxt_s)
  );

  // Setup-phase capture and wait-counter control.
  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    load_s  = 1'b0;
    en_s    = 1'b0;
    if ((state_q == IDLE) && psel && !penable) begin
      load_s  = 1'b1;
      addr_d  = paddr;
      write_d = pwrite;
      wdata_d = pwdata;
`ifdef APB_SLAVE_PSTRB_EN
      strb_d  = pstrb;
`else
      strb_d  = '1;
`endif
    end else if ((state_q == ACCESS) && psel && !(penable && pready_q)) begin
      en_s = !done_s;
    end else begin
      en_s = 1'b0;
    end
  end

  // Decode of the captured (or being-captured) address; addr_d equals addr_q throughout ACCESS.
  always_comb begin
    idx_s      = idx_of(64'(addr_d), DATA_W);
    in_range_s = (idx_s < 64'(NUM_REGS));
    sel_s      = idx_s[IDX_W-1:0];
    ro_s       = in_range_s ? RO_MASK[sel_s] : 1'b0;
    rdata_s    = '0;
    if (!in_range_s) begin
      rdata_s = '0;
    end else if (ro_s) begin
      rdata_s = ro_d[sel_s*DATA_W +: DATA_W];
    end else begin
      rdata_s = regs_q[sel_s*DATA_W +: DATA_W];
    end
    for (int b = 0; b < int'(LANES); b++) begin
      merged_s[b*8 +: 8] = strb_q[b] ? wdata_q[b*8 +: 8] : regs_q[sel_s*DATA_W + b*8 +: 8];
    end
  end

  // Next state, register commit and response.
  always_comb begin
    state_d   = state_q;
    regs_d    = regs_q;
    reg_wr_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (load_s) begin
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable && pready_q) begin
          state_d = IDLE;
          if (write_q && in_range_s && !ro_s) begin
            regs_d[sel_s*DATA_W +: DATA_W] = merged_s;
            reg_wr_d[sel_s]                = 1'b1;
          end else begin
            regs_d = regs_q;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_d == ACCESS) && done_nxt_s) begin
      pready_d  = 1'b1;
      pslverr_d = write_d ? (!in_range_s || ro_s) : !in_range_s;
      prdata_d  = write_d ? '0 : rdata_s;
    end else begin
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
    end
  end

  // FSM, capture registers, register bank and registered outputs.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      regs_q    <= '0;
      reg_wr_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      regs_q    <= regs_d;
      reg_wr_q  <= reg_wr_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign reg_q   = regs_q;
  assign reg_wr  = reg_wr_q;

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- Parametrised APB3 completer: a bank of NUM_REGS memory-mapped registers behind the apb_if signal set, with programmable wait states and error response.
- Generalises the fixed 32-bit, no-handshake slave port with configurable widths, pready/pslverr generation, read-only register masking and per-register write strobes.
- Sits between the APB interconnect and peripheral control/status logic; used as the DUT for the APB UVM agent tests.

Parameters:
- ADDR_W, 32, paddr width.
- DATA_W, 32, data width; legal values 8, 16 and 32.
- NUM_REGS, 16, number of registers; legal range 1..256.
- WAIT_CYCLES, 0, extra wait states per transfer; legal range 0..15.
- RO_MASK, '0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from ro_d.

Ports:
- pclk  in  1  APB clock; all logic on posedge.
- preset  in  1  synchronous reset, active-high.
- paddr  in  ADDR_W  byte address.
- psel  in  1  completer select.
- penable  in  1  access phase.
- pwrite  in  1  1=write, 0=read.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  error response.
- ro_d  in  NUM_REGS*DATA_W  read-only register values, flat, reg i at [i*DATA_W +: DATA_W].
- reg_q  out  NUM_REGS*DATA_W  RW register contents, same packing.
- reg_wr  out  NUM_REGS  one-cycle pulse when register i is written.

Behaviour:
- Clock and reset: one clock, pclk. Reset preset is synchronous and active-high.
- Reset values: prdata=0, pready=0, pslverr=0, reg_q=0, reg_wr=0, FSM=IDLE.
- Reset mid-transfer aborts the transfer with no register update.
- Decode:
  - Register index = paddr >> log2(DATA_W/8). Low byte-offset bits are ignored.
  - Index >= NUM_REGS is out of range.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on a sampled setup phase (psel=1, penable=0). At this edge: capture address, pwrite and pwdata, and load the wait counter cnt=0.
  - ACCESS: cnt increments each cycle while cnt<WAIT_CYCLES. pready, prdata and pslverr are registered.
  - pready=1 is driven in the cycle when cnt==WAIT_CYCLES. With WAIT_CYCLES=0 this is the first penable cycle, so there are no wait states.
  - ACCESS -> IDLE on the edge where psel&penable&pready is sampled. pready returns to 0 the next cycle.
  - ACCESS -> IDLE with no write if psel drops before completion.
- Write:
  - Commits on the completing edge: reg_q[i] <= pwdata and reg_wr[i] pulses for 1 cycle.
  - A write to a RO_MASK register or an out-of-range index does not update and returns pslverr=1.
- Read:
  - prdata = ro_d[i] if RO_MASK[i], else reg_q[i].
  - Out-of-range read: prdata=0, pslverr=1.
  - prdata is 0 whenever pready=0.
- pslverr is only ever 1 together with pready=1.
- Back-to-back: a setup phase sampled in the cycle after completion starts a new transfer. Total length is 2+WAIT_CYCLES cycles per transfer.
- penable=1 seen in IDLE without a prior setup phase is ignored and pready stays 0.
- paddr and pwdata changes during ACCESS are ignored, because they were captured at setup.

Optional Feature:
- Macro: APB_SLAVE_PSTRB_EN.
- When defined:
  - Adds input pstrb [DATA_W/8].
  - A write updates only the byte lanes with pstrb=1.
  - A write with pstrb=0 completes with pslverr=0 and no update; reg_wr still pulses.
- When undefined: all byte lanes are written.

Decomposition:
- Package apb_slave_pkg holds:
  - apb_state_e {IDLE, ACCESS}.
  - Function idx_of(addr) for the byte-offset shift.
  - Constant MAX_WAIT=15.
- Sub-module apb_wait_ctr holds the wait-state counter. It takes load/enable and outputs done=(cnt==WAIT_CYCLES).
- Register array and decode stay in the top.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x08 with WAIT_CYCLES=0 -> pready in the first penable cycle; reg_q[2]=0xDEADBEEF; reg_wr[2] pulses once; pslverr=0.
- WAIT_CYCLES=3, read addr 0x08 -> pready rises on the 4th penable cycle; prdata=0xDEADBEEF; prdata=0 before that.
- RO_MASK[1]=1 with ro_d[1]=0x12345678: write 0xFFFFFFFF to 0x04 then read it -> write returns pslverr=1 and no reg_wr; read returns 0x12345678 with pslverr=0.
- Read addr 0x40 with NUM_REGS=16 -> prdata=0, pslverr=1. Write to 0x40 -> pslverr=1, no reg_q change.
- preset asserted during a write's wait state with WAIT_CYCLES=5 -> next cycle pready=0 and the FSM is in IDLE; the register keeps its reset value 0.
- With APB_SLAVE_PSTRB_EN: reg=0x11223344, write 0xAABBCCDD with pstrb=4'b0101 -> reg=0x11BB33DD.
